// File: rtl/alu_reservation_station.sv
`default_nettype none
// ============================================================================
//  Module   : alu_reservation_station
//  Purpose  : ALU / branch-compare reservation station for the RV32I Tomasulo
//             core. Buffers issued ops, wakes operands from NUM_BCAST result
//             broadcast channels and from its own accepted result, selects one
//             ready entry per cycle into a registered ALU stage, and presents
//             the result through a valid/ready result register.
//  Ports    : clockIn/resetIn (async, active-low) clock and reset
//             readyIn   global enable (low = every register holds)
//             flushIn   synchronous clear of all entries and pipeline
//             add*      allocation request and operand/tag payload
//             full      no free entry
//             bcast*    flattened broadcast channels (valid/tag/value)
//             result*   result register valid/ready handshake and payload
//  Options  : define OLDEST_FIRST_EN for age-ordered select (default build
//             selects the lowest-index ready entry).
//  Revision : 1.0  initial release
// ============================================================================
module alu_reservation_station #(
    parameter int RS_DEPTH    = 16,
    parameter int ROB_WIDTH   = 4,
    parameter int RS_OP_WIDTH = 4,
    parameter int NUM_BCAST   = 2
) (
    input  logic                          clockIn,
    input  logic                          resetIn,
    input  logic                          readyIn,
    input  logic                          flushIn,
    input  logic                          addValid,
    input  logic [RS_OP_WIDTH-1:0]        addOp,
    input  logic [ROB_WIDTH-1:0]          addRobIndex,
    input  logic [31:0]                   addVal1,
    input  logic [31:0]                   addVal2,
    input  logic                          addHasDep1,
    input  logic                          addHasDep2,
    input  logic [ROB_WIDTH-1:0]          addConstrt1,
    input  logic [ROB_WIDTH-1:0]          addConstrt2,
    output logic                          full,
    input  logic [NUM_BCAST-1:0]          bcastValid,
    input  logic [NUM_BCAST*ROB_WIDTH-1:0] bcastRobIndex,
    input  logic [NUM_BCAST*32-1:0]       bcastVal,
    output logic                          resultValid,
    input  logic                          resultReady,
    output logic [ROB_WIDTH-1:0]          resultRobIndex,
    output logic [31:0]                   resultVal
);
    localparam int              c_IW   = $clog2(RS_DEPTH);
    localparam int              c_CW   = $clog2(RS_DEPTH + 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(RS_DEPTH);

    // Entry storage
    logic                   r_valid [RS_DEPTH];
    logic [RS_OP_WIDTH-1:0] r_op    [RS_DEPTH];
    logic [ROB_WIDTH-1:0]   r_rob   [RS_DEPTH];
    logic [31:0]            r_v1    [RS_DEPTH];
    logic [31:0]            r_v2    [RS_DEPTH];
    logic                   r_dep1  [RS_DEPTH];
    logic                   r_dep2  [RS_DEPTH];
    logic [ROB_WIDTH-1:0]   r_tag1  [RS_DEPTH];
    logic [ROB_WIDTH-1:0]   r_tag2  [RS_DEPTH];
    logic [c_CW-1:0]        r_count;
`ifdef OLDEST_FIRST_EN
    localparam int          c_AW = $clog2(RS_DEPTH) + 1;
    logic [c_AW-1:0]        r_age   [RS_DEPTH];
    logic [c_AW-1:0]        r_alloc_ctr;
    logic [c_AW-1:0]        w_dist;
    logic [c_AW-1:0]        w_best_dist;
`endif

    // ALU stage and result register
    logic                   r_alu_valid;
    logic [RS_OP_WIDTH-1:0] r_alu_op;
    logic [ROB_WIDTH-1:0]   r_alu_rob;
    logic [31:0]            r_alu_v1;
    logic [31:0]            r_alu_v2;
    logic                   r_res_valid;
    logic [ROB_WIDTH-1:0]   r_res_rob;
    logic [31:0]            r_res_val;

    logic                   w_own_acc;
    logic                   w_res_free;
    logic                   w_stage_take;
    logic                   w_add_acc;
    logic                   w_dispatch;
    logic                   w_sel_found;
    logic [c_IW-1:0]        w_sel_idx;
    logic                   w_free_found;
    logic [c_IW-1:0]        w_free_idx;
    logic [RS_DEPTH-1:0]    w_ready;
    logic [32:0]            w_snp1 [RS_DEPTH];
    logic [32:0]            w_snp2 [RS_DEPTH];
    logic [32:0]            w_add_snp1;
    logic [32:0]            w_add_snp2;
    logic [31:0]            w_alu_out;
    logic [4:0]             w_shamt;

    // Tag lookup: returns {hit, value}. Own accepted result is applied first
    // so any broadcast channel overrides it; channels are walked high to low
    // so the lowest channel index has the final word.
    function automatic logic [32:0] f_snoop(
        input logic [ROB_WIDTH-1:0]           tag,
        input logic [NUM_BCAST-1:0]           bv,
        input logic [NUM_BCAST*ROB_WIDTH-1:0] bt,
        input logic [NUM_BCAST*32-1:0]        bd,
        input logic                           own_v,
        input logic [ROB_WIDTH-1:0]           own_t,
        input logic [31:0]                    own_d
    );
        logic [32:0] v_res;
        v_res = 33'd0;
        if (own_v && (own_t == tag))
            v_res = {1'b1, own_d};
        for (int k = NUM_BCAST - 1; k >= 0; k--) begin
            if (bv[k] && (bt[k*ROB_WIDTH +: ROB_WIDTH] == tag))
                v_res = {1'b1, bd[k*32 +: 32]};
        end
        return v_res;
    endfunction

    assign w_own_acc    = r_res_valid && resultReady;
    assign w_res_free   = !r_res_valid || resultReady;
    assign w_stage_take = !r_alu_valid || w_res_free;
    assign full         = (r_count == c_FULL);
    assign w_add_acc    = addValid && !full && !flushIn;
    assign w_dispatch   = w_sel_found && w_stage_take;

    assign w_add_snp1 = f_snoop(addConstrt1, bcastValid, bcastRobIndex, bcastVal,
                                w_own_acc, r_res_rob, r_res_val);
    assign w_add_snp2 = f_snoop(addConstrt2, bcastValid, bcastRobIndex, bcastVal,
                                w_own_acc, r_res_rob, r_res_val);

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_snp1[i]  = f_snoop(r_tag1[i], bcastValid, bcastRobIndex, bcastVal,
                                 w_own_acc, r_res_rob, r_res_val);
            w_snp2[i]  = f_snoop(r_tag2[i], bcastValid, bcastRobIndex, bcastVal,
                                 w_own_acc, r_res_rob, r_res_val);
            w_ready[i] = r_valid[i] && !r_dep1[i] && !r_dep2[i];
        end
    end

    // Free-slot and ready-entry selection
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_sel_found  = 1'b0;
        w_sel_idx    = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = c_IW'(i);
            end
        end
`ifdef OLDEST_FIRST_EN
        // Distance back from the allocation counter: larger means older.
        w_dist      = '0;
        w_best_dist = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_dist = r_alloc_ctr - r_age[i];
            if (w_ready[i] && (!w_sel_found || (w_dist > w_best_dist))) begin
                w_sel_found = 1'b1;
                w_sel_idx   = c_IW'(i);
                w_best_dist = w_dist;
            end
        end
`else
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = c_IW'(i);
            end
        end
`endif
    end

    // Combinational ALU on the registered stage operands
    always_comb begin
        w_alu_out = 32'd0;
        w_shamt   = r_alu_v2[4:0];
        case (32'(r_alu_op))
            32'd0:   w_alu_out = r_alu_v1 + r_alu_v2;
            32'd1:   w_alu_out = r_alu_v1 - r_alu_v2;
            32'd2:   w_alu_out = r_alu_v1 ^ r_alu_v2;
            32'd3:   w_alu_out = r_alu_v1 | r_alu_v2;
            32'd4:   w_alu_out = r_alu_v1 & r_alu_v2;
            32'd5:   w_alu_out = r_alu_v1 << w_shamt;
            32'd6:   w_alu_out = r_alu_v1 >> w_shamt;
            32'd7:   w_alu_out = $unsigned($signed(r_alu_v1) >>> w_shamt);
            32'd8:   w_alu_out = {31'd0, (r_alu_v1 == r_alu_v2)};
            32'd9:   w_alu_out = {31'd0, (r_alu_v1 != r_alu_v2)};
            32'd10:  w_alu_out = {31'd0, ($signed(r_alu_v1) <  $signed(r_alu_v2))};
            32'd11:  w_alu_out = {31'd0, (r_alu_v1 <  r_alu_v2)};
            32'd12:  w_alu_out = {31'd0, ($signed(r_alu_v1) >= $signed(r_alu_v2))};
            32'd13:  w_alu_out = {31'd0, (r_alu_v1 >= r_alu_v2)};
            default: w_alu_out = 32'd0;
        endcase
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_op[i]    <= '0;
                r_rob[i]   <= '0;
                r_v1[i]    <= '0;
                r_v2[i]    <= '0;
                r_dep1[i]  <= 1'b0;
                r_dep2[i]  <= 1'b0;
                r_tag1[i]  <= '0;
                r_tag2[i]  <= '0;
`ifdef OLDEST_FIRST_EN
                r_age[i]   <= '0;
`endif
            end
`ifdef OLDEST_FIRST_EN
            r_alloc_ctr <= '0;
`endif
            r_count     <= '0;
            r_alu_valid <= 1'b0;
            r_alu_op    <= '0;
            r_alu_rob   <= '0;
            r_alu_v1    <= '0;
            r_alu_v2    <= '0;
            r_res_valid <= 1'b0;
            r_res_rob   <= '0;
            r_res_val   <= '0;
        end else if (readyIn) begin
            if (flushIn) begin
                for (int i = 0; i < RS_DEPTH; i++)
                    r_valid[i] <= 1'b0;
                r_count     <= '0;
                r_alu_valid <= 1'b0;
                r_res_valid <= 1'b0;
                r_res_rob   <= '0;
                r_res_val   <= '0;
            end else begin
                // Operand wake-up; a dispatched entry has no pending deps and
                // the allocated slot is invalid, so these never collide.
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (r_valid[i] && r_dep1[i] && w_snp1[i][32]) begin
                        r_v1[i]   <= w_snp1[i][31:0];
                        r_dep1[i] <= 1'b0;
                    end
                    if (r_valid[i] && r_dep2[i] && w_snp2[i][32]) begin
                        r_v2[i]   <= w_snp2[i][31:0];
                        r_dep2[i] <= 1'b0;
                    end
                end
                if (w_dispatch) begin
                    r_valid[w_sel_idx] <= 1'b0;
                end
                if (w_add_acc && w_free_found) begin
                    r_valid[w_free_idx] <= 1'b1;
                    r_op[w_free_idx]    <= addOp;
                    r_rob[w_free_idx]   <= addRobIndex;
                    r_tag1[w_free_idx]  <= addConstrt1;
                    r_tag2[w_free_idx]  <= addConstrt2;
                    r_dep1[w_free_idx]  <= addHasDep1 && !w_add_snp1[32];
                    r_dep2[w_free_idx]  <= addHasDep2 && !w_add_snp2[32];
                    r_v1[w_free_idx]    <= (addHasDep1 && w_add_snp1[32]) ? w_add_snp1[31:0] : addVal1;
                    r_v2[w_free_idx]    <= (addHasDep2 && w_add_snp2[32]) ? w_add_snp2[31:0] : addVal2;
`ifdef OLDEST_FIRST_EN
                    r_age[w_free_idx]   <= r_alloc_ctr;
                    r_alloc_ctr         <= r_alloc_ctr + 1'b1;
`endif
                end
                r_count <= r_count + c_CW'(w_add_acc && w_free_found) - c_CW'(w_dispatch);

                if (w_stage_take) begin
                    r_alu_valid <= w_sel_found;
                    if (w_sel_found) begin
                        r_alu_op  <= r_op[w_sel_idx];
                        r_alu_rob <= r_rob[w_sel_idx];
                        r_alu_v1  <= r_v1[w_sel_idx];
                        r_alu_v2  <= r_v2[w_sel_idx];
                    end
                end
                if (w_res_free) begin
                    r_res_valid <= r_alu_valid;
                    if (r_alu_valid) begin
                        r_res_rob <= r_alu_rob;
                        r_res_val <= w_alu_out;
                    end
                end
            end
        end
    end

    assign resultValid    = r_res_valid;
    assign resultRobIndex = r_res_rob;
    assign resultVal      = r_res_val;

endmodule
`default_nettype wire

// File: tb/tb_alu_reservation_station.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_reservation_station
//  Purpose  : Directed self-checking bench for alu_reservation_station with
//             hand-computed expected results (latency, wake-up, full,
//             backpressure, flush, readyIn hold, async reset, ALU ops).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_reservation_station;
    logic        clockIn = 1'b0;
    logic        resetIn;
    logic        readyIn;
    logic        flushIn;
    logic        addValid;
    logic [3:0]  addOp;
    logic [3:0]  addRobIndex;
    logic [31:0] addVal1, addVal2;
    logic        addHasDep1, addHasDep2;
    logic [3:0]  addConstrt1, addConstrt2;
    logic        full;
    logic [1:0]  bcastValid;
    logic [7:0]  bcastRobIndex;
    logic [63:0] bcastVal;
    logic        resultValid;
    logic        resultReady;
    logic [3:0]  resultRobIndex;
    logic [31:0] resultVal;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0]  c_op  [16];
    logic [31:0] c_a   [16];
    logic [31:0] c_b   [16];
    logic [31:0] c_exp [16];

    alu_reservation_station #(
        .RS_DEPTH(16), .ROB_WIDTH(4), .RS_OP_WIDTH(4), .NUM_BCAST(2)
    ) u_dut (
        .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn), .flushIn(flushIn),
        .addValid(addValid), .addOp(addOp), .addRobIndex(addRobIndex),
        .addVal1(addVal1), .addVal2(addVal2),
        .addHasDep1(addHasDep1), .addHasDep2(addHasDep2),
        .addConstrt1(addConstrt1), .addConstrt2(addConstrt2),
        .full(full), .bcastValid(bcastValid), .bcastRobIndex(bcastRobIndex),
        .bcastVal(bcastVal), .resultValid(resultValid), .resultReady(resultReady),
        .resultRobIndex(resultRobIndex), .resultVal(resultVal)
    );

    always #5 clockIn = ~clockIn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clockIn);
        #1;
    endtask

    task automatic drive_add(input logic [3:0] op, input logic [3:0] rob,
                             input logic [31:0] v1, input logic [31:0] v2,
                             input logic d1, input logic [3:0] t1,
                             input logic d2, input logic [3:0] t2);
        addValid    = 1'b1;
        addOp       = op;
        addRobIndex = rob;
        addVal1     = v1;
        addVal2     = v2;
        addHasDep1  = d1;
        addConstrt1 = t1;
        addHasDep2  = d2;
        addConstrt2 = t2;
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] rob,
                         input logic [31:0] v1, input logic [31:0] v2,
                         input logic d1, input logic [3:0] t1);
        drive_add(op, rob, v1, v2, d1, t1, 1'b0, 4'd0);
        tick();
        addValid = 1'b0;
    endtask

    task automatic bc(input int ch, input logic [3:0] tag, input logic [31:0] val);
        bcastValid[ch]          = 1'b1;
        bcastRobIndex[ch*4 +: 4] = tag;
        bcastVal[ch*32 +: 32]   = val;
    endtask

    task automatic bclr();
        bcastValid = 2'b00;
    endtask

    task automatic check_res(input string tag, input logic [3:0] rob, input logic [31:0] val);
        check({tag, " valid"}, {31'd0, resultValid}, 32'd1);
        check({tag, " rob"}, {28'd0, resultRobIndex}, {28'd0, rob});
        check({tag, " val"}, resultVal, val);
    endtask

    initial begin
        c_op[0]  = 4'd0;  c_a[0]  = 32'hFFFFFFFF; c_b[0]  = 32'd1;  c_exp[0]  = 32'd0;
        c_op[1]  = 4'd1;  c_a[1]  = 32'd3;        c_b[1]  = 32'd5;  c_exp[1]  = 32'hFFFFFFFE;
        c_op[2]  = 4'd5;  c_a[2]  = 32'd1;        c_b[2]  = 32'd33; c_exp[2]  = 32'd2;
        c_op[3]  = 4'd6;  c_a[3]  = 32'h80000000; c_b[3]  = 32'd4;  c_exp[3]  = 32'h08000000;
        c_op[4]  = 4'd7;  c_a[4]  = 32'h80000000; c_b[4]  = 32'd4;  c_exp[4]  = 32'hF8000000;
        c_op[5]  = 4'd8;  c_a[5]  = 32'd5;        c_b[5]  = 32'd5;  c_exp[5]  = 32'd1;
        c_op[6]  = 4'd9;  c_a[6]  = 32'd5;        c_b[6]  = 32'd5;  c_exp[6]  = 32'd0;
        c_op[7]  = 4'd10; c_a[7]  = 32'hFFFFFFFF; c_b[7]  = 32'd1;  c_exp[7]  = 32'd1;
        c_op[8]  = 4'd11; c_a[8]  = 32'hFFFFFFFF; c_b[8]  = 32'd1;  c_exp[8]  = 32'd0;
        c_op[9]  = 4'd12; c_a[9]  = 32'hFFFFFFFF; c_b[9]  = 32'd1;  c_exp[9]  = 32'd0;
        c_op[10] = 4'd13; c_a[10] = 32'hFFFFFFFF; c_b[10] = 32'd1;  c_exp[10] = 32'd1;
        c_op[11] = 4'd15; c_a[11] = 32'd3;        c_b[11] = 32'd4;  c_exp[11] = 32'd0;
        c_op[12] = 4'd14; c_a[12] = 32'd3;        c_b[12] = 32'd4;  c_exp[12] = 32'd0;
        c_op[13] = 4'd3;  c_a[13] = 32'hA0;       c_b[13] = 32'h0B; c_exp[13] = 32'hAB;
        c_op[14] = 4'd2;  c_a[14] = 32'hFF;       c_b[14] = 32'h0F; c_exp[14] = 32'hF0;
        c_op[15] = 4'd4;  c_a[15] = 32'hFF;       c_b[15] = 32'h0F; c_exp[15] = 32'h0F;

        resetIn = 1'b0; readyIn = 1'b1; flushIn = 1'b0; resultReady = 1'b1;
        bcastValid = 2'b00; bcastRobIndex = '0; bcastVal = '0;
        drive_add(4'd0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        addValid = 1'b0;
        tick(); tick();
        check("rst resultValid", {31'd0, resultValid}, 32'd0);
        check("rst rob", {28'd0, resultRobIndex}, 32'd0);
        check("rst val", resultVal, 32'd0);
        check("rst full", {31'd0, full}, 32'd0);
        resetIn = 1'b1;
        tick();

        // Independent ADD: result visible after the third edge.
        issue(4'd0, 4'd3, 32'd5, 32'd7, 1'b0, 4'd0);
        check("lat e1", {31'd0, resultValid}, 32'd0);
        tick();
        check("lat e2", {31'd0, resultValid}, 32'd0);
        tick();
        check_res("add5+7", 4'd3, 32'd12);
        check("add full", {31'd0, full}, 32'd0);
        tick();
        check("add drained", {31'd0, resultValid}, 32'd0);

        // Wake-up by broadcast channel 1 two cycles after allocation.
        issue(4'd1, 4'd2, 32'hDEAD, 32'd4, 1'b1, 4'd9);
        tick(); tick();
        bc(1, 4'd9, 32'd10);
        tick();
        bclr();
        check("wake e1", {31'd0, resultValid}, 32'd0);
        tick();
        check("wake e2", {31'd0, resultValid}, 32'd0);
        tick();
        check_res("wake sub", 4'd2, 32'd6);
        tick();

        // Capture at allocation; channel 0 beats channel 1.
        bc(0, 4'd9, 32'd20);
        bc(1, 4'd9, 32'd10);
        issue(4'd1, 4'd2, 32'hDEAD, 32'd4, 1'b1, 4'd9);
        bclr();
        tick(); tick();
        check_res("alloc prio", 4'd2, 32'd16);
        tick();

        // Forwarding from own accepted result at allocation.
        issue(4'd0, 4'd4, 32'd5, 32'd7, 1'b0, 4'd0);
        tick(); tick();
        check_res("fwd src", 4'd4, 32'd12);
        issue(4'd0, 4'd6, 32'hBAD, 32'd1, 1'b1, 4'd4);
        check("fwd gap", {31'd0, resultValid}, 32'd0);
        tick(); tick();
        check_res("fwd dst", 4'd6, 32'd13);
        tick();

        // Fill to full, ignored extra add, broadcast and drain.
        for (int i = 0; i < 16; i++) begin
            issue(4'd0, 4'(i), 32'd0, 32'(i), 1'b1, 4'd5);
            if (i == 14) check("full at 15", {31'd0, full}, 32'd0);
        end
        check("full at 16", {31'd0, full}, 32'd1);
        issue(4'd0, 4'd15, 32'd0, 32'd99, 1'b0, 4'd0);
        check("full extra", {31'd0, full}, 32'd1);
        bc(0, 4'd5, 32'd100);
        tick();
        bclr();
        check("full wake", {31'd0, full}, 32'd1);
        tick();
        check("full drop", {31'd0, full}, 32'd0);
        tick();
        for (int i = 0; i < 16; i++) begin
            check_res($sformatf("drain%0d", i), 4'(i), 32'(100 + i));
            tick();
        end
        check("drain end", {31'd0, resultValid}, 32'd0);

        // Backpressure holds the result; release yields the rest in order.
        resultReady = 1'b0;
        issue(4'd4, 4'd1, 32'hF0F0, 32'hFF00, 1'b0, 4'd0);
        issue(4'd2, 4'd2, 32'hF0, 32'hFF, 1'b0, 4'd0);
        issue(4'd3, 4'd3, 32'h100, 32'h1, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            check_res("bp hold", 4'd1, 32'hF000);
            tick();
        end
        check_res("bp hold", 4'd1, 32'hF000);
        resultReady = 1'b1;
        tick();
        check_res("bp 2nd", 4'd2, 32'h0F);
        tick();
        check_res("bp 3rd", 4'd3, 32'h101);
        tick();
        check("bp end", {31'd0, resultValid}, 32'd0);

        // Flush with entries, ALU stage and result register occupied.
        resultReady = 1'b0;
        for (int i = 0; i < 4; i++)
            issue(4'd0, 4'(8 + i), 32'(i), 32'd1, 1'b0, 4'd0);
        check_res("pre flush", 4'd8, 32'd1);
        flushIn = 1'b1;
        drive_add(4'd0, 4'd12, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        flushIn = 1'b0;
        addValid = 1'b0;
        check("flush valid", {31'd0, resultValid}, 32'd0);
        check("flush rob", {28'd0, resultRobIndex}, 32'd0);
        check("flush val", resultVal, 32'd0);
        check("flush full", {31'd0, full}, 32'd0);
        resultReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("flush empty", {31'd0, resultValid}, 32'd0);
        end

        // ALU op table at one op per cycle.
        for (int j = 0; j < 18; j++) begin
            if (j < 16) drive_add(c_op[j], 4'(j), c_a[j], c_b[j], 1'b0, 4'd0, 1'b0, 4'd0);
            else        addValid = 1'b0;
            tick();
            if (j >= 2) check_res($sformatf("alu%0d", j - 2), 4'(j - 2), c_exp[j - 2]);
        end
        addValid = 1'b0;
        tick();
        check("alu end", {31'd0, resultValid}, 32'd0);

        // readyIn=0 freezes state, including broadcast capture.
        issue(4'd1, 4'd1, 32'd0, 32'd1, 1'b1, 4'd13);
        readyIn = 1'b0;
        bc(0, 4'd13, 32'd50);
        tick();
        bclr();
        tick(); tick();
        readyIn = 1'b1;
        tick(); tick(); tick();
        check("hold nocap", {31'd0, resultValid}, 32'd0);
        bc(0, 4'd13, 32'd50);
        tick();
        bclr();
        tick(); tick();
        check_res("hold wake", 4'd1, 32'd49);
        readyIn = 1'b0;
        tick(); tick();
        check_res("hold res", 4'd1, 32'd49);
        readyIn = 1'b1;
        tick();
        check("hold drain", {31'd0, resultValid}, 32'd0);

        // Asynchronous reset between edges clears outputs immediately.
        issue(4'd0, 4'd7, 32'd2, 32'd3, 1'b0, 4'd0);
        tick(); tick();
        check_res("pre arst", 4'd7, 32'd5);
        #2 resetIn = 1'b0;
        #1;
        check("arst valid", {31'd0, resultValid}, 32'd0);
        check("arst rob", {28'd0, resultRobIndex}, 32'd0);
        check("arst val", resultVal, 32'd0);
        check("arst full", {31'd0, full}, 32'd0);
        tick();
        resetIn = 1'b1;
        tick();

`ifdef OLDEST_FIRST_EN
        // Older entry at index 1 beats a younger ready entry at index 0.
        issue(4'd0, 4'd1, 32'd0, 32'd1, 1'b1, 4'd7);
        issue(4'd0, 4'd2, 32'd0, 32'd2, 1'b1, 4'd8);
        bc(0, 4'd7, 32'd10);
        tick();
        bclr();
        tick();
        bc(0, 4'd8, 32'd20);
        issue(4'd0, 4'd3, 32'd30, 32'd3, 1'b0, 4'd0);
        bclr();
        check_res("age A", 4'd1, 32'd11);
        tick(); tick();
        check_res("age B", 4'd2, 32'd22);
        tick();
        check_res("age C", 4'd3, 32'd33);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Parametrised next-generation ALU reservation station for the RV32I Tomasulo core.
- Buffers up to RS_DEPTH ALU/branch-compare ops from the issue unit and snoops NUM_BCAST result-broadcast channels (CDB, load/store buffer, other units) for operand wake-up.
- Selects one ready entry per cycle into a registered ALU stage, then a result register drained by a valid/ready handshake.
- Adds flush and backpressure.

Parameters:
- RS_DEPTH, 16, number of entries (any value 2..32, not restricted to powers of two).
- ROB_WIDTH, 4, ROB index width.
- RS_OP_WIDTH, 4, ALU opcode width.
- NUM_BCAST, 2, number of external broadcast channels snooped.

Ports:
- clockIn  in  1  clock, rising edge.
- resetIn  in  1  asynchronous, active-low reset.
- readyIn  in  1  global enable; low = all state holds.
- flushIn  in  1  synchronous clear (branch mispredict).
- addValid  in  1  allocate an entry this cycle.
- addOp  in  RS_OP_WIDTH  opcode.
- addRobIndex  in  ROB_WIDTH  destination ROB tag.
- addVal1, addVal2  in  32  operand values.
- addHasDep1, addHasDep2  in  1  operand waits on a tag.
- addConstrt1, addConstrt2  in  ROB_WIDTH  tag waited on.
- full  out  1  no free entry.
- bcastValid  in  NUM_BCAST  per-channel broadcast valid.
- bcastRobIndex  in  NUM_BCAST*ROB_WIDTH  flattened tags; channel k at [k*ROB_WIDTH +: ROB_WIDTH].
- bcastVal  in  NUM_BCAST*32  flattened values.
- resultValid  out  1  result register holds a result.
- resultReady  in  1  consumer accepts the result.
- resultRobIndex  out  ROB_WIDTH  tag of the result.
- resultVal  out  32  result value.

Behaviour:
- Reset (resetIn=0, async):
  - all entries invalid; count=0; ALU stage empty.
  - resultValid=0, resultRobIndex=0, resultVal=0; full=0.
- readyIn=0: no state changes, including broadcast capture. Outputs hold their values.
- Opcodes:
  - 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 EQ, 9 NE, 10 LT, 11 LTU, 12 GE, 13 GEU.
  - Compares return 32'd1/32'd0. Shifts use v2[4:0] only. Opcodes 14/15 return 0.
- full = (count == RS_DEPTH), combinational from registered count. addValid while full is ignored; the issue unit must not do this.
- Allocation: lowest-index free entry. Operands are merged the same edge:
  - If a dependency tag matches any valid broadcast channel or the accepted own result (resultValid&&resultReady), capture that value and clear the dependency.
  - Lowest channel index wins; own result has the lowest priority.
- Wake-up: each valid entry with a pending dependency captures a matching broadcast or own accepted result at the edge. Same priority as allocation.
- Select:
  - Entry is ready = valid && !hasDep1 && !hasDep2.
  - Winner is the lowest index (see optional feature).
  - Dispatch happens when a ready entry exists and the ALU stage is empty or advancing. The winner is invalidated the same edge.
- Pipeline:
  - ALU stage register → combinational ALU → result register.
  - ALU stage advances when the result register is empty or resultValid&&resultReady.
  - An entry added with both operands ready gives resultValid 3 edges after the add edge (add, dispatch, result).
  - Throughput is 1/cycle with resultReady=1.
- Backpressure: resultValid=1 && resultReady=0 holds the result register and ALU stage. Entries keep waking up.
- Count: count_next = count + add_accepted - dispatched; both may occur in the same cycle.
- flushIn=1 (when readyIn=1), next edge:
  - all entries, ALU stage and result register cleared; resultValid=0.
  - addValid in the same cycle is discarded; count=0.
  - Flush takes precedence over every other update.

Optional Feature:
- OLDEST_FIRST_EN defined:
  - each entry carries an age stamp from a wrapping allocation counter of width $clog2(RS_DEPTH)+1.
  - select picks the ready entry with the oldest stamp, compared relative to the current counter so wrap-around is handled.
  - Ties are impossible.
- Not defined: lowest-index select, no age storage.

Test Plan:
- Independent op: add ADD 5,7 tag 3, resultReady=1 → resultValid on 3rd edge, resultRobIndex=3, resultVal=12; full=0, count returns to 0.
- Dependency wake-up: add SUB tag 2, dep1 on tag 9, val2=4; 2 cycles later bcast ch1 tag 9 val 10 → resultVal=6, tag 2. Also drive bcast tag 9 in the add cycle itself → captured at allocation, same result.
- Fill/full: 16 adds all dep on tag 5, no broadcast → full=1 after 16th; extra add ignored. Broadcast tag 5 → 16 results drain in 16 consecutive cycles; full drops after first dispatch.
- Backpressure: resultReady=0 with 3 ready ops → resultValid stuck on first; release → remaining 2 emerge back-to-back, none lost or duplicated.
- Flush mid-flight: 4 entries, one in ALU stage, one in result register; flushIn=1 → next cycle resultValid=0, count=0, full=0. A concurrent addValid is dropped.
- Async reset mid-operation: drop resetIn between edges → outputs zero immediately. SLL 1,33 → 2; LT 0xFFFFFFFF,1 → 1; opcode 15 → 0; with OLDEST_FIRST_EN, older ready entry at higher index issues first.
